router_output_ctrl: RTL

- Output-side controller of one ring direction (cw or ccw) in the router; the counterpart of the router input controller.
- Collects request/grant transfers from two internal requesters: port 0 is the opposite ring input, port 1 is the local PE injection.
- Stores each accepted packet in one of two virtual-channel (VC) buffers: even = 0, odd = 1. Drives the outgoing link with a valid/ready handshake gated by `polarity`.
- Shifts the hop field right by one on every accepted packet.

---
 rtl/router_output_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/router_output_ctrl.sv
// Output-side controller for one ring direction: arbitrates two requesters into two
// phase-interleaved VC buffers and drives the outgoing valid/ready link.
module router_output_ctrl #(
  parameter int unsigned DW      = 64,
  parameter int unsigned HOP_MSB = 55,
  parameter int unsigned HOP_LSB = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          polarity,
  input  logic [1:0]    in2out_req,
  output logic [1:0]    out2in_gnt,
  input  logic [DW-1:0] in2out_din0,
  input  logic [DW-1:0] in2out_din1,
  output logic          out2ch_vld,
  input  logic          ch2out_rdy,
  output logic [DW-1:0] out2ch_dout,
  output logic          out_vc_err
);

  localparam int unsigned HopW = HOP_MSB - HOP_LSB + 1;

  logic [DW-1:0] obuf_q [2];
  logic [DW-1:0] obuf_d [2];
  logic [1:0]    full_q, full_d;
  logic          rr_last_q, rr_last_d;
  logic          vc_err_q, vc_err_d;

  logic          wr_idx;
  logic          rd_idx;
  logic [1:0]    gnt;
  logic [DW-1:0] sel_din;
  logic [DW-1:0] din_mod;
  logic [HopW-1:0] hop;
  logic          send;

  // Internal side fills obuf[~p] while the link drains obuf[p].
  assign wr_idx = ~polarity;
  assign rd_idx = polarity;

  always_comb begin
    gnt = 2'b00;
    if (!rst && !full_q[wr_idx]) begin
      case (in2out_req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign sel_din = gnt[1] ? in2out_din1 : in2out_din0;
  assign hop     = sel_din[HOP_MSB:HOP_LSB];

  always_comb begin
    din_mod                  = sel_din;
    din_mod[HOP_MSB:HOP_LSB] = hop >> 1;
  end

  assign out2ch_vld  = full_q[rd_idx] & ~rst;
  assign out2ch_dout = out2ch_vld ? obuf_q[rd_idx] : '0;
  assign send        = out2ch_vld & ch2out_rdy;
  assign out2in_gnt  = gnt;
  assign out_vc_err  = vc_err_q;

  always_comb begin
    full_d    = full_q;
    obuf_d    = obuf_q;
    rr_last_d = rr_last_q;
    vc_err_d  = vc_err_q;
    if (send) begin
      full_d[rd_idx] = 1'b0;
    end
    if (|gnt) begin
      full_d[wr_idx] = 1'b1;
      obuf_d[wr_idx] = din_mod;
      rr_last_d      = gnt[1];
      // Packet is still stored on a VC mismatch; only the sticky flag records it.
      if (sel_din[DW-1] != wr_idx) begin
        vc_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      obuf_q[0] <= '0;
      obuf_q[1] <= '0;
      full_q    <= 2'b00;
      rr_last_q <= 1'b1;
      vc_err_q  <= 1'b0;
    end else begin
      obuf_q[0] <= obuf_d[0];
      obuf_q[1] <= obuf_d[1];
      full_q    <= full_d;
      rr_last_q <= rr_last_d;
      vc_err_q  <= vc_err_d;
    end
  end

endmodule
